// File: rtl/serial_adder_pkg.sv
// rtl/serial_adder_pkg.sv - shared types and limits for the bit-serial adder
package serial_adder_pkg;

  // Controller states.
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // Legal operand width range.
  localparam int WIDTH_MIN = 2;
  localparam int WIDTH_MAX = 32;

endpackage

// File: rtl/full_adder_cell.sv
// rtl/full_adder_cell.sv - combinational full adder from two half adders
module full_adder_cell (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  logic s1;
  logic c1;
  logic c2;

  half_adder u_ha0 (
    .a (a),
    .b (b),
    .s (s1),
    .c (c1)
  );

  half_adder u_ha1 (
    .a (s1),
    .b (cin),
    .s (sum),
    .c (c2)
  );

  // Either half adder generating a carry produces the cell carry.
  assign cout = c1 | c2;

endmodule

// File: rtl/half_adder.sv
// rtl/half_adder.sv - one-bit half adder
module half_adder (
  input  logic a,
  input  logic b,
  output logic s,
  output logic c
);

  assign s = a ^ b;
  assign c = a & b;

endmodule

// File: rtl/serial_adder_ctrl.sv
// rtl/serial_adder_ctrl.sv - bit-serial adder controller, one bit per clock LSB first
module serial_adder_ctrl
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] Sum,
  output logic             Carry
);

  localparam int CW = $clog2(WIDTH);

  generate
    if (WIDTH < WIDTH_MIN || WIDTH > WIDTH_MAX) begin : g_width_check
      $error("serial_adder_ctrl: WIDTH out of range");
    end
  endgenerate

  state_t           state;
  state_t           state_next;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic [WIDTH-1:0] res;
  logic [CW-1:0]    cnt;
  logic             carry_ff;
  logic             cell_sum;
  logic             cell_cout;
  logic             last_bit;

  assign last_bit = (cnt == CW'(WIDTH - 1));

  full_adder_cell u_cell (
    .a    (op_a[0]),
    .b    (op_b[0]),
    .cin  (carry_ff),
    .sum  (cell_sum),
    .cout (cell_cout)
  );

  // Next-state logic: accept start only in IDLE, leave RUN after the MSB.
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:  if (start) state_next = S_RUN;
      S_RUN:   if (last_bit) state_next = S_DONE;
      S_DONE:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_next;
  end

  // Status flags registered from the next state so they align with the state.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      busy <= (state_next != S_IDLE);
      done <= (state_next == S_DONE);
    end
  end

  // Datapath: operand capture, serial shifting and result publication.
  always_ff @(posedge clk) begin
    if (rst) begin
      op_a     <= '0;
      op_b     <= '0;
      res      <= '0;
      cnt      <= '0;
      carry_ff <= 1'b0;
      Sum      <= '0;
      Carry    <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            op_a     <= A;
            op_b     <= B;
            res      <= '0;
            cnt      <= '0;
            carry_ff <= 1'b0;
          end
        end
        S_RUN: begin
          res      <= {cell_sum, res[WIDTH-1:1]};
          op_a     <= op_a >> 1;
          op_b     <= op_b >> 1;
          carry_ff <= cell_cout;
          cnt      <= cnt + CW'(1);
          // Publish only the complete result so Sum never shows partial bits.
          if (last_bit) begin
            Sum   <= {cell_sum, res[WIDTH-1:1]};
            Carry <= cell_cout;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// tb/tb_serial_adder_ctrl.sv - self-checking bench for serial_adder_ctrl
module tb_serial_adder_ctrl;
  import serial_adder_pkg::*;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] A;
  logic [W-1:0] B;
  logic         busy;
  logic         done;
  logic [W-1:0] Sum;
  logic         Carry;

  typedef struct packed {
    logic [W-1:0] sum;
    logic         carry;
  } exp_t;

  exp_t         sb[$];
  int           total = 0;
  int           bad = 0;
  int           done_count = 0;
  logic [W-1:0] prev_sum;
  logic         prev_carry;

  serial_adder_ctrl #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .A     (A),
    .B     (B),
    .busy  (busy),
    .done  (done),
    .Sum   (Sum),
    .Carry (Carry)
  );

  always #5 clk = ~clk;

  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W:0] t;
    exp_t e;
    t = {1'b0, a} + {1'b0, b};
    e.sum = t[W-1:0];
    e.carry = t[W];
    return e;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: every done pulse pops one expected result.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (done) begin
      done_count++;
      if (sb.size() == 0) begin
        chk("sb_underflow", 32'd1, 32'd0);
      end else begin
        e = sb.pop_front();
        chk("sb_sum", 32'(Sum), 32'(e.sum));
        chk("sb_carry", 32'(Carry), 32'(e.carry));
      end
    end
  end

  task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input string tag);
    exp_t e;
    int   lat;
    int   bcnt;
    e = model(a, b);
    @(negedge clk);
    start = 1'b1;
    A = a;
    B = b;
    sb.push_back(e);
    @(negedge clk);
    start = 1'b0;
    A = W'($urandom);
    B = W'($urandom);
    lat = 0;
    bcnt = 0;
    for (int k = 1; k <= 40; k++) begin
      if (k > 1) @(negedge clk);
      if (busy) bcnt++;
      if (done && lat == 0) begin
        lat = k;
        prev_sum = e.sum;
        prev_carry = e.carry;
      end else begin
        chk({tag, "_hold_sum"}, 32'(Sum), 32'(prev_sum));
        chk({tag, "_hold_carry"}, 32'(Carry), 32'(prev_carry));
      end
      if (lat != 0 && !busy) break;
    end
    chk({tag, "_latency"}, 32'(lat), 32'(W + 1));
    chk({tag, "_busy_cycles"}, 32'(bcnt), 32'(W + 1));
  endtask

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1);
  end

  initial begin : stim
    exp_t e;
    int   dc0;
    int   p;
    int   t[3];

    rst = 1'b1;
    start = 1'b0;
    A = '0;
    B = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_sum", 32'(Sum), 32'd0);
    chk("rst_carry", 32'(Carry), 32'd0);
    rst = 1'b0;
    prev_sum = '0;
    prev_carry = 1'b0;

    do_op(8'h00, 8'h00, "zero");
    do_op(8'hFF, 8'h01, "ff_01");
    do_op(8'hA5, 8'h5A, "a5_5a");
    do_op(8'h80, 8'h80, "80_80");
    do_op(8'h3C, 8'h0F, "3c_0f");

    // Start pulsed during RUN must be ignored.
    dc0 = done_count;
    e = model(8'h12, 8'h34);
    @(negedge clk);
    start = 1'b1;
    A = 8'h12;
    B = 8'h34;
    sb.push_back(e);
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    start = 1'b1;
    A = 8'hFF;
    B = 8'hFF;
    @(negedge clk);
    start = 1'b0;
    repeat (30) @(negedge clk);
    chk("ignore_done_pulses", 32'(done_count - dc0), 32'd1);
    chk("ignore_sb_empty", 32'(sb.size()), 32'd0);
    chk("ignore_sum", 32'(Sum), 32'h46);
    chk("ignore_carry", 32'(Carry), 32'd0);
    prev_sum = e.sum;
    prev_carry = e.carry;

    // Reset during the 4th RUN cycle aborts the operation.
    @(negedge clk);
    start = 1'b1;
    A = 8'hFF;
    B = 8'hFF;
    sb.push_back(model(8'hFF, 8'hFF));
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    sb.delete();
    chk("abort_state", 32'(dut.state), 32'(S_IDLE));
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_sum", 32'(Sum), 32'd0);
    chk("abort_carry", 32'(Carry), 32'd0);
    chk("abort_cnt", 32'(dut.cnt), 32'd0);
    chk("abort_carry_ff", 32'(dut.carry_ff), 32'd0);
    prev_sum = '0;
    prev_carry = 1'b0;
    do_op(8'h01, 8'h01, "after_abort");

    // Start held high: back-to-back results every W+2 cycles.
    e = model(8'h01, 8'h02);
    repeat (3) sb.push_back(e);
    p = 0;
    @(negedge clk);
    start = 1'b1;
    A = 8'h01;
    B = 8'h02;
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk);
      if (done) begin
        if (p < 3) t[p] = n;
        p++;
        prev_sum = e.sum;
        prev_carry = e.carry;
        if (p == 3) start = 1'b0;
      end else begin
        chk("held_hold_sum", 32'(Sum), 32'(prev_sum));
      end
    end
    start = 1'b0;
    chk("held_pulses", 32'(p), 32'd3);
    chk("held_gap0", 32'(t[1] - t[0]), 32'(W + 2));
    chk("held_gap1", 32'(t[2] - t[1]), 32'(W + 2));

    repeat (3) @(negedge clk);
    chk("final_sb_empty", 32'(sb.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/serial_adder_ctrl.md
# serial_adder_ctrl

Bit-serial adder controller. It time-multiplexes one 1-bit full-adder cell, built from two `half_adder` instances, across a WIDTH-bit addition, processing one bit per clock from the LSB up. It captures operands on a start request and sequences the cell with a bit counter and a carry flip-flop. It presents a registered Sum/Carry with a one-cycle done pulse. It is the low-area alternative to a parallel ripple adder in the building-blocks set.

## Interface
- WIDTH, default 8: operand and result width; legal range 2..32.
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- start  in  1  request; sampled only in IDLE.
- A  in  WIDTH  operand A; captured on the accepted start edge.
- B  in  WIDTH  operand B; captured on the accepted start edge.
- busy  out  1  high in RUN and DONE.
- done  out  1  one-cycle pulse; Sum and Carry are valid from this cycle.
- Sum  out  WIDTH  registered result; holds its value until the next DONE.
- Carry  out  1  registered carry-out of the MSB.

## Operation
- States:
  - IDLE: waiting for a request.
  - RUN: one operand bit per cycle.
  - DONE: single cycle.
- IDLE -> RUN when start=1.
  - Load opA<=A and opB<=B.
  - Clear carry FF and bit counter.
  - Clear result shift register.
- RUN, each cycle:
  - Cell inputs are opA[0], opB[0], carry FF.
  - Cell sum bit shifts into the result register MSB; the register shifts right.
  - opA and opB shift right.
  - Carry FF <= cell carry.
  - Counter increments.
- RUN -> DONE when the counter reaches WIDTH-1 and that bit is processed, i.e. after exactly WIDTH RUN cycles.
  - On this transition, Sum <= final result register and Carry <= final carry.
- DONE -> IDLE unconditionally after one cycle.
- start is ignored in RUN and DONE; it is not queued.
- A and B may change freely after the accepted start edge without effect.
- Arithmetic: {Carry, Sum} = A + B, modulo 2^(WIDTH+1). No signed interpretation.
- Counter width: $clog2(WIDTH).
- Reset in any state, including mid-RUN, aborts the operation. On the next edge:
  - state=IDLE.
  - busy=0, done=0, Sum=0, Carry=0.
  - carry FF, counter and internal shift registers = 0.
- Sum and Carry never show partial results; they change only on entry to DONE or on reset.

## Timing
- Edge E0: start=1 in IDLE is accepted.
- busy=1 from E0+1.
- RUN occupies cycles E0+1 .. E0+WIDTH.
- done=1 for the single cycle after edge E0+WIDTH; new Sum and Carry are visible in the same cycle.
- busy=0 and done=0 after edge E0+WIDTH+1.
- Latency, start edge to done: WIDTH+1 cycles.
- If start is held high continuously, throughput is one result every WIDTH+2 cycles. The IDLE cycle after DONE accepts the next request.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Structure
- Shared package serial_adder_pkg:
  - typedef enum logic [1:0] state_t {S_IDLE, S_RUN, S_DONE}.
  - WIDTH range check constants.
- Sub-module full_adder_cell:
  - Two `half_adder` instances plus an OR gate for carry.
  - Purely combinational.
  - The sole arithmetic element.
- Top level contains the FSM, counter, operand shift registers, result register and carry FF.

## Test plan
- WIDTH=8, reset then A=0x00, B=0x00, start pulse -> done pulse at E0+9, Sum=0x00, Carry=0; busy high for exactly 9 cycles.
- A=0xFF, B=0x01 -> Sum=0x00, Carry=1. Then A=0xA5, B=0x5A -> Sum=0xFF, Carry=0, with no stale carry from the first operation.
- A=0x80, B=0x80 -> Sum=0x00, Carry=1. A=0x3C, B=0x0F -> Sum=0x4B, Carry=0.
- Start with A=0x12, B=0x34; during RUN pulse start with A=0xFF, B=0xFF -> second request ignored; Sum=0x46, Carry=0; exactly one done pulse.
- Assert rst in the 4th RUN cycle of A=0xFF, B=0xFF -> next edge: IDLE, busy=0, done=0, Sum=0x00, Carry=0. Then A=0x01, B=0x01 -> Sum=0x02, Carry=0.
- Hold start=1 with constant A=0x01, B=0x02 -> done pulses spaced 10 cycles apart; Sum=0x03 each time; Sum stays stable between pulses.
